gfx_frame_scanout: RTL and testbench

Responder end of the VRAM/draw interface driven by the graphics test harness: a 2048×16 frame buffer with a single-cycle host access port, plus a draw handshake that streams a captured frame out as bytes. It sits between the CPU-side frame copier (which writes VRAM words, then pulses draw when ready) and the serial byte transmitter feeding the display link. The host never sees the memory mid-scan: all host access is dropped while a scan is in progress.

---
 rtl/gfx_frame_scanout.sv | 100 ++++++++++
 tb/tb_gfx_frame_scanout.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_frame_scanout.sv
// Frame buffer with a single-cycle host port and a draw handshake that
// streams the captured frame out as a header byte followed by big-endian words.
module gfx_frame_scanout #(
  parameter int          ADDR_BITS = 11,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        VRAM_EN,
  input  logic        VRAM_WE,
  input  logic [15:0] VRAM_ADDR,
  input  logic [15:0] VRAM_DATA_W,
  output logic [15:0] VRAM_DATA_R,
  output logic        GPU_READY,
  input  logic        GPU_DRAW,
  output logic [7:0]  TX_DATA,
  output logic        TX_VALID,
  input  logic        TX_READY
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  typedef enum logic [2:0] {IDLE, HDR, RD, HI, LO} scanState_t;

  scanState_t           state;
  scanState_t           nextState;
  logic [15:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] scanAddr;
  logic [15:0]          word;

  logic                 hostInRange;
  logic [ADDR_BITS-1:0] hostAddr;
  logic                 hostWrite;
  logic                 hostRead;
  logic                 lastWord;

  assign hostInRange = (VRAM_ADDR[15:ADDR_BITS] == '0);
  assign hostAddr    = VRAM_ADDR[ADDR_BITS-1:0];
  // The host port is only live while idle, so a scan always sees a frozen frame.
  assign hostWrite   = (state == IDLE) && VRAM_EN && VRAM_WE && hostInRange;
  assign hostRead    = (state == IDLE) && VRAM_EN && !VRAM_WE;
  assign lastWord    = (scanAddr == ADDR_BITS'(DEPTH - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (GPU_DRAW) nextState = HDR;
      HDR:  if (TX_READY) nextState = RD;
      RD:   nextState = HI;
      HI:   if (TX_READY) nextState = LO;
      LO:   if (TX_READY) nextState = lastWord ? IDLE : RD;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    GPU_READY = (state == IDLE);
    TX_VALID  = 1'b0;
    TX_DATA   = 8'h00;
    unique case (state)
      HDR: begin TX_VALID = 1'b1; TX_DATA = HEADER;     end
      HI:  begin TX_VALID = 1'b1; TX_DATA = word[15:8]; end
      LO:  begin TX_VALID = 1'b1; TX_DATA = word[7:0];  end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      scanAddr    <= '0;
      word        <= 16'h0000;
      VRAM_DATA_R <= 16'h0000;
    end else begin
      if (state == IDLE && GPU_DRAW)
        scanAddr <= '0;
      else if (state == LO && TX_READY && !lastWord)
        scanAddr <= scanAddr + 1'b1;

      if (state == RD)
        word <= mem[scanAddr];

      if (hostWrite)
        VRAM_DATA_R <= VRAM_DATA_W;
      else if (hostRead)
        VRAM_DATA_R <= hostInRange ? mem[hostAddr] : 16'h0000;
    end
  end

  // Frame contents survive reset.
  always_ff @(posedge CLK) begin
    if (hostWrite)
      mem[hostAddr] <= VRAM_DATA_W;
  end

endmodule

// File: tb/tb_gfx_frame_scanout.sv
// Bench for gfx_frame_scanout: host port, full and stalled scans, busy rules
// and reset mid-scan, each checked against a frame-level byte model.
module tb_gfx_frame_scanout;

  localparam int         ADDR_BITS = 11;
  localparam int         DEPTH     = 2 ** ADDR_BITS;
  localparam logic [7:0] HEADER    = 8'hA5;
  localparam int         SCAN_CYCLES = 2 + 3 * DEPTH;
  localparam int         CYCLE_LIMIT = 20000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        VRAM_EN;
  logic        VRAM_WE;
  logic [15:0] VRAM_ADDR;
  logic [15:0] VRAM_DATA_W;
  logic [15:0] VRAM_DATA_R;
  logic        GPU_READY;
  logic        GPU_DRAW;
  logic [7:0]  TX_DATA;
  logic        TX_VALID;
  logic        TX_READY;

  int checks   = 0;
  int failures = 0;

  logic [15:0] memModel [DEPTH];
  logic [7:0]  exp_q [$];
  logic [7:0]  got_q [$];

  gfx_frame_scanout #(.ADDR_BITS(ADDR_BITS), .HEADER(HEADER)) dut (
    .CLK(CLK), .RESET(RESET),
    .VRAM_EN(VRAM_EN), .VRAM_WE(VRAM_WE), .VRAM_ADDR(VRAM_ADDR),
    .VRAM_DATA_W(VRAM_DATA_W), .VRAM_DATA_R(VRAM_DATA_R),
    .GPU_READY(GPU_READY), .GPU_DRAW(GPU_DRAW),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY)
  );

  always #5 CLK = ~CLK;

  // Expected frame: header, then each word high byte first.
  function automatic void buildExpected();
    exp_q.delete();
    exp_q.push_back(HEADER);
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(memModel[i][15:8]);
      exp_q.push_back(memModel[i][7:0]);
    end
  endfunction

  function automatic int countMismatch(input int n);
    int m = 0;
    for (int i = 0; i < n; i++)
      if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  // Driver tasks start and end 1 time unit after a rising edge.
  task automatic hostWrite(input logic [15:0] a, input logic [15:0] d);
    VRAM_EN = 1'b1; VRAM_WE = 1'b1; VRAM_ADDR = a; VRAM_DATA_W = d;
    @(posedge CLK); #1;
    VRAM_EN = 1'b0; VRAM_WE = 1'b0;
    if (a < DEPTH) memModel[a] = d;
  endtask

  task automatic hostRead(input logic [15:0] a, output logic [15:0] r);
    VRAM_EN = 1'b1; VRAM_WE = 1'b0; VRAM_ADDR = a;
    @(posedge CLK); #1;
    r = VRAM_DATA_R;
    VRAM_EN = 1'b0;
  endtask

  // Pulses draw, then runs cycle by cycle collecting transferred bytes.
  // cycles is the index of the cycle in which GPU_READY is seen high again,
  // counting the cycle right after the accepting edge as 1.
  task automatic runScan(input int readyPct, input bit poke, input int abortWords,
                         output int stalls, output int cycles, output int stabErr,
                         output bit firstOk);
    bit         prevHold = 1'b0;
    logic [7:0] prevData = 8'h00;
    got_q.delete();
    stalls = 0; stabErr = 0;
    GPU_DRAW = 1'b1;
    @(posedge CLK); #1;
    GPU_DRAW = 1'b0; VRAM_EN = 1'b0; VRAM_WE = 1'b0;
    cycles = 1;
    firstOk = (GPU_READY === 1'b0) && (TX_VALID === 1'b1) && (TX_DATA === HEADER);
    while (GPU_READY !== 1'b1 && cycles < CYCLE_LIMIT) begin
      if (abortWords > 0 && got_q.size() >= 1 + 2 * abortWords) break;
      TX_READY = (readyPct >= 100) ? 1'b1 : ($urandom_range(0, 99) < readyPct);
      if (poke && cycles == 50) begin
        VRAM_EN = 1'b1; VRAM_WE = 1'b1; VRAM_ADDR = 16'h0000;
        VRAM_DATA_W = 16'hFFFF; GPU_DRAW = 1'b1;
      end else begin
        VRAM_EN = 1'b0; VRAM_WE = 1'b0; GPU_DRAW = 1'b0;
      end
      @(negedge CLK);
      if (prevHold && (TX_VALID !== 1'b1 || TX_DATA !== prevData)) stabErr++;
      if (TX_VALID === 1'b1 && TX_READY) got_q.push_back(TX_DATA);
      if (TX_VALID === 1'b1 && !TX_READY) stalls++;
      prevHold = (TX_VALID === 1'b1) && !TX_READY;
      prevData = TX_DATA;
      @(posedge CLK); #1;
      cycles++;
    end
    VRAM_EN = 1'b0; VRAM_WE = 1'b0; GPU_DRAW = 1'b0; TX_READY = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; VRAM_EN = 1'b0; VRAM_WE = 1'b0; VRAM_ADDR = 16'h0;
    VRAM_DATA_W = 16'h0; GPU_DRAW = 1'b0; TX_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (GPU_READY !== 1'b1 || TX_VALID !== 1'b0 || TX_DATA !== 8'h00 || VRAM_DATA_R !== 16'h0) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b data=%h rd=%h, required 1 0 00 0000",
               GPU_READY, TX_VALID, TX_DATA, VRAM_DATA_R);
    end
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_host_port();
    logic [15:0] r;
    hostWrite(16'd5, 16'h1234);
    checks++;
    if (VRAM_DATA_R !== 16'h1234) begin
      failures++; $display("FAIL write_echo: got %h required 1234", VRAM_DATA_R);
    end
    hostWrite(16'd2047, 16'hBEEF);
    hostWrite(16'd0, 16'h0BAD);
    hostRead(16'd5, r);
    checks++;
    if (r !== 16'h1234) begin failures++; $display("FAIL read_5: got %h required 1234", r); end
    @(posedge CLK); #1;
    checks++;
    if (VRAM_DATA_R !== 16'h1234) begin
      failures++; $display("FAIL read_hold: got %h required 1234", VRAM_DATA_R);
    end
    hostRead(16'd2047, r);
    checks++;
    if (r !== 16'hBEEF) begin failures++; $display("FAIL read_2047: got %h required beef", r); end
    hostWrite(16'h0800, 16'h5555);
    hostRead(16'h0800, r);
    checks++;
    if (r !== 16'h0000) begin failures++; $display("FAIL read_oor: got %h required 0000", r); end
    hostRead(16'd0, r);
    checks++;
    if (r !== memModel[0]) begin
      failures++; $display("FAIL oor_no_alias: got %h required %h", r, memModel[0]);
    end
  endtask

  task automatic test_full_scan();
    int stalls, cycles, stabErr; bit firstOk;
    for (int i = 0; i < DEPTH; i++) hostWrite(16'(i), 16'(i));
    buildExpected();
    runScan(100, 1'b0, 0, stalls, cycles, stabErr, firstOk);
    checks++;
    if (!firstOk) begin failures++; $display("FAIL full_first_cycle: header cycle wrong, required ready=0 valid=1 data=a5"); end
    checks++;
    if (got_q.size() != 1 + 2 * DEPTH) begin
      failures++; $display("FAIL full_count: got %0d bytes required %0d", got_q.size(), 1 + 2 * DEPTH);
    end
    checks++;
    if (countMismatch(exp_q.size()) != 0) begin
      failures++; $display("FAIL full_stream: %0d bytes differ, required 0", countMismatch(exp_q.size()));
    end
    checks++;
    if (cycles != SCAN_CYCLES) begin
      failures++; $display("FAIL full_timing: ready at N+%0d required N+%0d", cycles, SCAN_CYCLES);
    end
  endtask

  task automatic test_backpressure();
    int stalls, cycles, stabErr; bit firstOk;
    runScan(50, 1'b0, 0, stalls, cycles, stabErr, firstOk);
    checks++;
    if (countMismatch(exp_q.size()) != 0 || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL bp_stream: %0d bytes differ, %0d received, required 0 and %0d",
                           countMismatch(exp_q.size()), got_q.size(), exp_q.size());
    end
    checks++;
    if (stabErr != 0) begin failures++; $display("FAIL bp_stable: %0d unstable holds required 0", stabErr); end
    checks++;
    if (cycles != SCAN_CYCLES + stalls) begin
      failures++; $display("FAIL bp_timing: ready at N+%0d required N+%0d", cycles, SCAN_CYCLES + stalls);
    end
  endtask

  task automatic test_busy();
    int stalls, cycles, stabErr; bit firstOk;
    logic [15:0] held, r;
    hostRead(16'd0, held);
    runScan(70, 1'b1, 0, stalls, cycles, stabErr, firstOk);
    checks++;
    if (countMismatch(exp_q.size()) != 0 || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL busy_stream: %0d bytes differ, %0d received", countMismatch(exp_q.size()), got_q.size());
    end
    checks++;
    if (cycles != SCAN_CYCLES + stalls) begin
      failures++; $display("FAIL busy_timing: ready at N+%0d required N+%0d", cycles, SCAN_CYCLES + stalls);
    end
    checks++;
    if (VRAM_DATA_R !== memModel[0]) begin
      failures++; $display("FAIL busy_rd_hold: got %h required %h", VRAM_DATA_R, memModel[0]);
    end
    hostRead(16'd0, r);
    checks++;
    if (r !== memModel[0]) begin failures++; $display("FAIL busy_mem0: got %h required %h", r, memModel[0]); end
    @(posedge CLK); #1;
    checks++;
    if (GPU_READY !== 1'b1) begin failures++; $display("FAIL busy_no_redraw: ready=%b required 1", GPU_READY); end
  endtask

  task automatic test_reset_mid_scan();
    int stalls, cycles, stabErr; bit firstOk;
    logic [15:0] r;
    hostRead(16'd2047, r);
    runScan(100, 1'b0, 100, stalls, cycles, stabErr, firstOk);
    checks++;
    if (got_q.size() != 201 || countMismatch(201) != 0) begin
      failures++; $display("FAIL partial_stream: %0d bytes, %0d differ, required 201 and 0", got_q.size(), countMismatch(201));
    end
    #3;
    RESET = 1'b1;
    #1;
    checks++;
    if (GPU_READY !== 1'b1 || TX_VALID !== 1'b0 || TX_DATA !== 8'h00 || VRAM_DATA_R !== 16'h0) begin
      failures++;
      $display("FAIL async_reset: ready=%b valid=%b data=%h rd=%h, required 1 0 00 0000",
               GPU_READY, TX_VALID, TX_DATA, VRAM_DATA_R);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_random_scan();
    int stalls, cycles, stabErr; bit firstOk;
    logic [15:0] a, d;
    for (int i = 0; i < 300; i++)
      hostWrite(16'($urandom_range(0, DEPTH - 1)), 16'($urandom));
    a = 16'($urandom_range(0, DEPTH - 1));
    d = 16'($urandom);
    VRAM_EN = 1'b1; VRAM_WE = 1'b1; VRAM_ADDR = a; VRAM_DATA_W = d;
    memModel[a] = d;
    buildExpected();
    runScan(50, 1'b0, 0, stalls, cycles, stabErr, firstOk);
    checks++;
    if (!firstOk) begin failures++; $display("FAIL rand_first_cycle: header cycle wrong after reset"); end
    checks++;
    if (countMismatch(exp_q.size()) != 0 || got_q.size() != exp_q.size()) begin
      failures++; $display("FAIL rand_stream: %0d bytes differ, %0d received, required 0 and %0d",
                           countMismatch(exp_q.size()), got_q.size(), exp_q.size());
    end
    checks++;
    if (stabErr != 0) begin failures++; $display("FAIL rand_stable: %0d unstable holds required 0", stabErr); end
    checks++;
    if (cycles != SCAN_CYCLES + stalls) begin
      failures++; $display("FAIL rand_timing: ready at N+%0d required N+%0d", cycles, SCAN_CYCLES + stalls);
    end
  endtask

  initial begin
    test_reset();
    test_host_port();
    test_full_scan();
    test_backpressure();
    test_busy();
    test_reset_mid_scan();
    test_random_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
